// File: rtl/is_group_sched_pkg.sv
// Shared constants and types for the IS-stage issue scheduler.
package is_group_sched_pkg;
  localparam int PHY_W_DEF   = 6;
  localparam int ISSUE_W_DEF = 2;
  localparam int WB_W_DEF    = 2;
  localparam int SLOT_CNT    = 4;
  localparam int ALUOP_W     = 9;

  typedef logic [1:0]           slot_idx_t;
  typedef logic [PHY_W_DEF-1:0] tag_t;
endpackage

// File: rtl/is_group_sched_if.sv
// Pipeline-side bundle of the issue scheduler: IS slots, allocation, writeback, FU ports, stall.
interface is_group_sched_if #(
  parameter int PHY_W   = 6,
  parameter int ISSUE_W = 2,
  parameter int WB_W    = 2
);
  import is_group_sched_pkg::*;

  logic                      flush;
  logic [SLOT_CNT-1:0]       is_valid;
  logic [SLOT_CNT*PHY_W-1:0] is_src1;
  logic [SLOT_CNT*PHY_W-1:0] is_src2;
  logic [SLOT_CNT-1:0]       alloc_valid;
  logic [SLOT_CNT*PHY_W-1:0] alloc_tag;
  logic [WB_W-1:0]           wb_valid;
  logic [WB_W*PHY_W-1:0]     wb_tag;
  logic [ISSUE_W-1:0]        port_rdy;
  logic [ISSUE_W-1:0]        iss_valid;
  logic [ISSUE_W*2-1:0]      iss_slot;
  logic                      stall_o;

  modport master (
    output flush, is_valid, is_src1, is_src2, alloc_valid, alloc_tag,
           wb_valid, wb_tag, port_rdy,
    input  iss_valid, iss_slot, stall_o
  );

  modport slave (
    input  flush, is_valid, is_src1, is_src2, alloc_valid, alloc_tag,
           wb_valid, wb_tag, port_rdy,
    output iss_valid, iss_slot, stall_o
  );
endinterface

// File: rtl/is_group_sched_rdy_table.sv
// Physical-register ready table: writeback sets, allocation clears, reads see same-cycle writeback.
module phys_ready_table #(
  parameter int PHY_W = 6,
  parameter int WB_W  = 2,
  parameter int CLR_N = 4,
  parameter int RD_N  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [WB_W-1:0]        set_valid,
  input  logic [WB_W*PHY_W-1:0]  set_tag,
  input  logic [CLR_N-1:0]       clr_valid,
  input  logic [CLR_N*PHY_W-1:0] clr_tag,
  input  logic [RD_N*PHY_W-1:0]  rd_tag,
  output logic [RD_N-1:0]        rd_ok
);
  localparam int NUM_PHYS = 2 ** PHY_W;

  logic [NUM_PHYS-1:0] rdy_q, rdy_d;

  // Clears are applied after sets so an allocation wins over a same-cycle writeback.
  always_comb begin
    rdy_d = rdy_q;
    for (int j = 0; j < WB_W; j++) begin
      if (set_valid[j]) rdy_d[set_tag[j*PHY_W +: PHY_W]] = 1'b1;
    end
    for (int c = 0; c < CLR_N; c++) begin
      if (clr_valid[c]) rdy_d[clr_tag[c*PHY_W +: PHY_W]] = 1'b0;
    end
    rdy_d[0] = 1'b1;
    if (flush) rdy_d = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) rdy_q <= '1;
    else     rdy_q <= rdy_d;
  end

  for (genvar gi = 0; gi < RD_N; gi++) begin : g_rd
    logic wb_hit;
    always_comb begin
      wb_hit = 1'b0;
      for (int j = 0; j < WB_W; j++) begin
        if (set_valid[j] && (set_tag[j*PHY_W +: PHY_W] == rd_tag[gi*PHY_W +: PHY_W]))
          wb_hit = 1'b1;
      end
    end
    assign rd_ok[gi] = rdy_q[rd_tag[gi*PHY_W +: PHY_W]] | wb_hit;
  end
endmodule

// File: rtl/is_group_sched.sv
// In-order group issue: sends ready IS slots to free FU ports in program order and stalls
// the IS register until every valid slot of the group has gone.
module is_group_sched
  import is_group_sched_pkg::*;
#(
  parameter int PHY_W   = PHY_W_DEF,
  parameter int ISSUE_W = ISSUE_W_DEF,
  parameter int WB_W    = WB_W_DEF
) (
  input logic             clk,
  input logic             rst,
  is_group_sched_if.slave bus
);
  localparam int RD_N = 2 * SLOT_CNT;

  logic [SLOT_CNT-1:0]   done_q, done_d;
  logic [SLOT_CNT-1:0]   elig, issued_now, pend;
  logic [RD_N*PHY_W-1:0] rd_tag;
  logic [RD_N-1:0]       rd_ok;
  logic [ISSUE_W-1:0]    iss_valid_c;
  logic [ISSUE_W*2-1:0]  iss_slot_c;
  logic                  kill, stall;

  assign kill = rst | bus.flush;

  // Read port 2i checks source 1 of slot i, port 2i+1 checks source 2.
  for (genvar gi = 0; gi < SLOT_CNT; gi++) begin : g_slot
    assign rd_tag[(2*gi)*PHY_W +: PHY_W]   = bus.is_src1[gi*PHY_W +: PHY_W];
    assign rd_tag[(2*gi+1)*PHY_W +: PHY_W] = bus.is_src2[gi*PHY_W +: PHY_W];
    assign elig[gi] = bus.is_valid[gi] & ~done_q[gi] & rd_ok[2*gi] & rd_ok[2*gi+1];
  end

  phys_ready_table #(
    .PHY_W (PHY_W),
    .WB_W  (WB_W),
    .CLR_N (SLOT_CNT),
    .RD_N  (RD_N)
  ) u_rdy (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .set_valid (bus.wb_valid),
    .set_tag   (bus.wb_tag),
    .clr_valid (bus.alloc_valid),
    .clr_tag   (bus.alloc_tag),
    .rd_tag    (rd_tag),
    .rd_ok     (rd_ok)
  );

  // The first pending slot that cannot go (not ready, or no port left) blocks all younger ones.
  always_comb begin : issue_sel
    int   next_port;
    int   sel;
    logic found;
    logic blocked;
    issued_now  = '0;
    iss_valid_c = '0;
    iss_slot_c  = '0;
    next_port   = 0;
    sel         = 0;
    found       = 1'b0;
    blocked     = 1'b0;
    for (int i = 0; i < SLOT_CNT; i++) begin
      if (bus.is_valid[i] && !done_q[i] && !blocked) begin
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < ISSUE_W; k++) begin
          if (!found && (k >= next_port) && bus.port_rdy[k]) begin
            found = 1'b1;
            sel   = k;
          end
        end
        if (found && elig[i] && !kill) begin
          issued_now[i]          = 1'b1;
          iss_valid_c[sel]       = 1'b1;
          iss_slot_c[sel*2 +: 2] = slot_idx_t'(i);
          next_port              = sel + 1;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  assign pend  = bus.is_valid & ~done_q & ~issued_now;
  assign stall = (|pend) & ~kill;

  // While stalled the group is held and its issued slots accumulate; otherwise a new group loads.
  always_comb begin
    done_d = '0;
    if (!kill && stall) done_d = done_q | issued_now;
  end

  always_ff @(posedge clk) begin
    if (rst) done_q <= '0;
    else     done_q <= done_d;
  end

  assign bus.iss_valid = iss_valid_c;
  assign bus.iss_slot  = iss_slot_c;
  assign bus.stall_o   = stall;
endmodule

// File: tb/tb_is_group_sched.sv
// Directed bench for is_group_sched: inputs change on the falling edge, outputs checked 1 ns later.
module tb_is_group_sched;
  localparam int PW = 6;
  localparam int IW = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  is_group_sched_if #(.PHY_W(PW), .ISSUE_W(IW), .WB_W(WW)) bus ();

  is_group_sched #(.PHY_W(PW), .ISSUE_W(IW), .WB_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] v, input logic [3:0] s,
                            input logic st);
    logic [3:0] m;
    #1;
    m = {{2{v[1]}}, {2{v[0]}}};
    chk({tag, ".valid"}, 8'(bus.iss_valid), 8'(v));
    chk({tag, ".slot"},  8'(bus.iss_slot & m), 8'(s & m));
    chk({tag, ".stall"}, 8'(bus.stall_o), 8'(st));
    $display("step %-10s iss_valid=%b iss_slot=%b stall_o=%b", tag, bus.iss_valid,
             bus.iss_slot, bus.stall_o);
  endtask

  task automatic idle();
    bus.flush       = 1'b0;
    bus.is_valid    = '0;
    bus.is_src1     = '0;
    bus.is_src2     = '0;
    bus.alloc_valid = '0;
    bus.alloc_tag   = '0;
    bus.wb_valid    = '0;
    bus.wb_tag      = '0;
    bus.port_rdy    = 2'b11;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.is_valid = 4'hF;
    expect_out("rst", 2'b00, 4'b0000, 1'b0);

    // Group of four ready slots over two ports
    next_cycle(); rst = 1'b0; bus.is_valid = 4'hF;
    expect_out("t1c0", 2'b11, 4'b0100, 1'b1);
    next_cycle(); bus.is_valid = 4'hF;
    expect_out("t1c1", 2'b11, 4'b1110, 1'b0);
    next_cycle(); bus.is_valid = 4'hF;
    expect_out("t1c2", 2'b11, 4'b0100, 1'b1);
    next_cycle();
    expect_out("empty1", 2'b00, 4'b0000, 1'b0);

    // Wait on allocated tag 5, then issue via writeback bypass
    next_cycle(); bus.alloc_valid = 4'b0001; bus.alloc_tag[0 +: PW] = 6'd5;
    expect_out("t2alloc", 2'b00, 4'b0000, 1'b0);
    next_cycle(); bus.is_valid = 4'b0001; bus.is_src1[0 +: PW] = 6'd5;
    expect_out("t2wait", 2'b00, 4'b0000, 1'b1);
    next_cycle(); bus.is_valid = 4'b0001; bus.is_src1[0 +: PW] = 6'd5;
    bus.wb_valid = 2'b01; bus.wb_tag[0 +: PW] = 6'd5;
    expect_out("t2byp", 2'b01, 4'b0000, 1'b0);

    // Slot1 blocked on tag 9 must hold back ready slot2
    next_cycle(); bus.alloc_valid = 4'b0010; bus.alloc_tag[PW +: PW] = 6'd9;
    expect_out("t3alloc", 2'b00, 4'b0000, 1'b0);
    next_cycle(); bus.is_valid = 4'b0111; bus.is_src2[PW +: PW] = 6'd9;
    expect_out("t3c0", 2'b01, 4'b0000, 1'b1);
    next_cycle(); bus.is_valid = 4'b0111; bus.is_src2[PW +: PW] = 6'd9;
    expect_out("t3c1", 2'b00, 4'b0000, 1'b1);
    next_cycle(); bus.is_valid = 4'b0111; bus.is_src2[PW +: PW] = 6'd9;
    bus.wb_valid = 2'b10; bus.wb_tag[PW +: PW] = 6'd9;
    expect_out("t3wb", 2'b11, 4'b1001, 1'b0);

    // Port availability
    next_cycle(); bus.is_valid = 4'b0011; bus.port_rdy = 2'b10;
    expect_out("t4c0", 2'b10, 4'b0000, 1'b1);
    next_cycle(); bus.is_valid = 4'b0011; bus.port_rdy = 2'b11;
    expect_out("t4c1", 2'b01, 4'b0001, 1'b0);
    next_cycle(); bus.is_valid = 4'b0001; bus.port_rdy = 2'b00;
    expect_out("t4none", 2'b00, 4'b0000, 1'b1);
    next_cycle(); bus.is_valid = 4'b0001; bus.port_rdy = 2'b01;
    expect_out("t4p0", 2'b01, 4'b0000, 1'b0);

    // Alloc beats same-cycle writeback on tag 7; tag 0 stays ready
    next_cycle(); bus.alloc_valid = 4'b0011;
    bus.alloc_tag[0 +: PW] = 6'd7; bus.alloc_tag[PW +: PW] = 6'd0;
    bus.wb_valid = 2'b11; bus.wb_tag[0 +: PW] = 6'd7; bus.wb_tag[PW +: PW] = 6'd0;
    expect_out("t5both", 2'b00, 4'b0000, 1'b0);
    next_cycle(); bus.is_valid = 4'hF; bus.is_src1[2*PW +: PW] = 6'd7;
    expect_out("t5c0", 2'b11, 4'b0100, 1'b1);

    // Flush mid-group with slots 0,1 done
    next_cycle(); bus.is_valid = 4'hF; bus.is_src1[2*PW +: PW] = 6'd7; bus.flush = 1'b1;
    expect_out("t6flush", 2'b00, 4'b0000, 1'b0);
    next_cycle(); bus.is_valid = 4'hF; bus.is_src1[2*PW +: PW] = 6'd7;
    expect_out("t6c0", 2'b11, 4'b0100, 1'b1);
    next_cycle(); bus.is_valid = 4'hF; bus.is_src1[2*PW +: PW] = 6'd7;
    expect_out("t6c1", 2'b11, 4'b1110, 1'b0);

    next_cycle();
    expect_out("empty2", 2'b00, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
